// File: rtl/modbus_scan_master.sv
// Modbus RTU request initiator: snapshots the scan CSRs, streams an 8-byte request
// with CRC-16/Modbus, then applies response timeout, retry and scan-period pacing.
module modbus_scan_master #(
  parameter int unsigned CYCLES_PER_MS = 50000,
  parameter int unsigned RESP_TO_MS    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [3:0]  scan_retry_max,
  input  logic [15:0] scan_period_ms,
  input  logic [7:0]  scan_slave,
  input  logic [7:0]  scan_func,
  input  logic [15:0] scan_start_addr,
  input  logic [15:0] scan_qty,
  input  logic [15:0] scan_wdata,
  output logic [7:0]  tx_b,
  output logic        tx_b_v,
  input  logic        tx_b_rdy,
  input  logic        rsp_frame_end,
  input  logic        rsp_ok,
  output logic        req_pending,
  output logic        busy,
  output logic        stat_timeout,
  output logic [15:0] scan_cycles_done,
  output logic [15:0] scan_err_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_RSP, S_WAIT_PERIOD} state_t;

  localparam int unsigned PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;

  state_t      state;
  logic [PW-1:0] pre;
  logic [15:0] ms_cnt, ms_nxt;
  logic        tick, timeout, period_done, func_ok;
  logic [7:0]  frame [0:5];
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  byte_nxt;
  logic [15:0] crc, crc_nxt;
  logic [3:0]  retry_cnt, retry_max;
  logic [15:0] period;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    tick        = (pre == PW'(CYCLES_PER_MS - 1));
    ms_nxt      = ms_cnt + 16'd1;
    timeout     = tick && (ms_nxt == 16'(RESP_TO_MS));
    period_done = (period == 16'd0) || (tick && (ms_nxt == period));
    func_ok     = (scan_func >= 8'h01) && (scan_func <= 8'h06);
    crc_nxt     = crc_step(crc, tx_b);
    idx_nxt     = idx + 3'd1;
    // CRC_lo must come from the CRC that includes the byte being accepted now
    case (idx_nxt)
      3'd1:    byte_nxt = frame[1];
      3'd2:    byte_nxt = frame[2];
      3'd3:    byte_nxt = frame[3];
      3'd4:    byte_nxt = frame[4];
      3'd5:    byte_nxt = frame[5];
      3'd6:    byte_nxt = crc_nxt[7:0];
      default: byte_nxt = crc[15:8];
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign req_pending = (state == S_WAIT_RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      pre              <= '0;
      ms_cnt           <= '0;
      idx              <= '0;
      crc              <= '1;
      retry_cnt        <= '0;
      retry_max        <= '0;
      period           <= '0;
      tx_b             <= '0;
      tx_b_v           <= 1'b0;
      stat_timeout     <= 1'b0;
      scan_cycles_done <= '0;
      scan_err_count   <= '0;
      for (int unsigned i = 0; i < 6; i++) frame[i] <= '0;
    end else begin
      stat_timeout <= 1'b0;
      if (state == S_WAIT_RSP || state == S_WAIT_PERIOD) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) ms_cnt <= ms_nxt;
      end
      case (state)
        S_IDLE: if (scan_en) state <= S_LOAD;
        S_LOAD: begin
          frame[0]  <= scan_slave;
          frame[1]  <= scan_func;
          frame[2]  <= scan_start_addr[15:8];
          frame[3]  <= scan_start_addr[7:0];
          frame[4]  <= (scan_func >= 8'h05) ? scan_wdata[15:8] : scan_qty[15:8];
          frame[5]  <= (scan_func >= 8'h05) ? scan_wdata[7:0]  : scan_qty[7:0];
          retry_max <= scan_retry_max;
          period    <= scan_period_ms;
          retry_cnt <= '0;
          crc       <= '1;
          idx       <= '0;
          if (func_ok) begin
            tx_b   <= scan_slave;
            tx_b_v <= 1'b1;
            state  <= S_SEND;
          end else begin
            scan_err_count <= scan_err_count + 16'd1;
            pre            <= '0;
            ms_cnt         <= '0;
            state          <= S_WAIT_PERIOD;
          end
        end
        S_SEND: if (tx_b_rdy) begin
          if (idx == 3'd7) begin
            tx_b_v <= 1'b0;
            pre    <= '0;
            ms_cnt <= '0;
            state  <= S_WAIT_RSP;
          end else begin
            if (idx <= 3'd5) crc <= crc_nxt;
            tx_b <= byte_nxt;
            idx  <= idx_nxt;
          end
        end
        S_WAIT_RSP: begin
          if (!scan_en) begin
            state <= S_IDLE;
          end else if (rsp_frame_end && rsp_ok) begin
            scan_cycles_done <= scan_cycles_done + 16'd1;
            retry_cnt        <= '0;
            pre              <= '0;
            ms_cnt           <= '0;
            state            <= S_WAIT_PERIOD;
          end else if (rsp_frame_end || timeout) begin
            stat_timeout <= !rsp_frame_end;
            if (retry_cnt < retry_max) begin
              retry_cnt <= retry_cnt + 4'd1;
              crc       <= '1;
              idx       <= '0;
              tx_b      <= frame[0];
              tx_b_v    <= 1'b1;
              state     <= S_SEND;
            end else begin
              scan_err_count <= scan_err_count + 16'd1;
              retry_cnt      <= '0;
              pre            <= '0;
              ms_cnt         <= '0;
              state          <= S_WAIT_PERIOD;
            end
          end
        end
        S_WAIT_PERIOD: begin
          if (!scan_en)         state <= S_IDLE;
          else if (period_done) state <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_scan_master.sv
// Directed bench for modbus_scan_master with hand-computed RTU frames and timings.
module tb_modbus_scan_master;

  localparam int unsigned CPM = 10;
  localparam int unsigned RTO = 8;
  localparam logic [63:0] F_RD = 64'h0103_0000_000A_C5CD;
  localparam logic [63:0] F_WR = 64'h0106_0001_0003_980B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b0;
  logic [3:0]  scan_retry_max = '0;
  logic [15:0] scan_period_ms = 16'd2;
  logic [7:0]  scan_slave = 8'h01;
  logic [7:0]  scan_func = 8'h03;
  logic [15:0] scan_start_addr = 16'h0000;
  logic [15:0] scan_qty = 16'h000A;
  logic [15:0] scan_wdata = 16'h0000;
  logic        tx_b_rdy = 1'b0;
  logic        rsp_frame_end = 1'b0;
  logic        rsp_ok = 1'b0;
  logic [7:0]  tx_b;
  logic        tx_b_v, req_pending, busy, stat_timeout;
  logic [15:0] scan_cycles_done, scan_err_count;

  int n_vec = 0;
  int n_bad = 0;
  int to_cnt = 0;

  modbus_scan_master #(.CYCLES_PER_MS(CPM), .RESP_TO_MS(RTO)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_retry_max(scan_retry_max),
    .scan_period_ms(scan_period_ms), .scan_slave(scan_slave), .scan_func(scan_func),
    .scan_start_addr(scan_start_addr), .scan_qty(scan_qty), .scan_wdata(scan_wdata),
    .tx_b(tx_b), .tx_b_v(tx_b_v), .tx_b_rdy(tx_b_rdy), .rsp_frame_end(rsp_frame_end),
    .rsp_ok(rsp_ok), .req_pending(req_pending), .busy(busy), .stat_timeout(stat_timeout),
    .scan_cycles_done(scan_cycles_done), .scan_err_count(scan_err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stat_timeout) to_cnt <= to_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Collects 8 accepted bytes; optionally toggles ready and drops scan_en after drop_at bytes.
  task automatic get_frame(input bit toggle, input int drop_at, output logic [63:0] fb,
                           output int span, output int holds);
    int n, k, first;
    logic stalled;
    logic [7:0] last;
    n = 0; k = 0; first = -1; stalled = 1'b0; last = '0;
    fb = '0; span = 0; holds = 0;
    while (k < 8 && n < 300) begin
      @(negedge clk);
      n++;
      tx_b_rdy = toggle ? n[0] : 1'b1;
      if (tx_b_v) begin
        if (first < 0) first = n;
        if (stalled && tx_b !== last) holds++;
        if (tx_b_rdy) begin
          fb = {fb[55:0], tx_b};
          k++;
          stalled = 1'b0;
          span = n - first + 1;
          if (k == drop_at) scan_en = 1'b0;
        end else begin
          stalled = 1'b1;
          last = tx_b;
        end
      end
    end
    check_eq("frame_bytes", k, 8);
    @(posedge clk);
    #1 tx_b_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] fb;
    int span, holds, n, vseen;

    repeat (3) @(negedge clk);
    check_eq("rst_tx_b_v", tx_b_v, 0);
    check_eq("rst_tx_b", tx_b, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_pending", req_pending, 0);
    check_eq("rst_cycles", scan_cycles_done, 0);
    check_eq("rst_err", scan_err_count, 0);
    check_eq("rst_timeout", stat_timeout, 0);
    rst = 1'b0;

    // FC03 read, ready always high
    scan_en = 1'b1;
    get_frame(1'b0, -1, fb, span, holds);
    check_eq("t1_frame", fb, F_RD);
    check_eq("t1_span", span, 8);
    repeat (2) @(negedge clk);
    check_eq("t1_req_pending", req_pending, 1);
    check_eq("t1_busy", busy, 1);

    // Good response 50 cycles after CRC_hi, then a 2 ms period gap
    repeat (48) @(negedge clk);
    rsp_frame_end = 1'b1; rsp_ok = 1'b1;
    @(negedge clk);
    rsp_frame_end = 1'b0; rsp_ok = 1'b0;
    scan_func = 8'h06; scan_start_addr = 16'h0001; scan_wdata = 16'h0003; scan_qty = 16'hFFFF;
    n = 0;
    while (!tx_b_v && n < 100) begin @(negedge clk); n++; end
    check_eq("t3_gap", n, 21);
    check_eq("t3_cycles", scan_cycles_done, 1);

    // FC06 with toggling ready; CSR change after load must not leak into the frame
    scan_slave = 8'h55;
    get_frame(1'b1, -1, fb, span, holds);
    check_eq("t2_frame", fb, F_WR);
    check_eq("t2_hold", holds, 0);
    repeat (5) @(negedge clk);
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t2_abort_busy", busy, 0);
    check_eq("t2_abort_cycles", scan_cycles_done, 1);
    check_eq("t2_abort_err", scan_err_count, 0);
    check_eq("t2_abort_to", to_cnt, 0);

    // No response, two retries
    scan_slave = 8'h01; scan_func = 8'h03; scan_start_addr = 16'h0000; scan_qty = 16'h000A;
    scan_retry_max = 4'd2; scan_period_ms = 16'd0;
    scan_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      get_frame(1'b0, -1, fb, span, holds);
      check_eq("t4_frame", fb, F_RD);
    end
    n = 0;
    while (!stat_timeout && n < 200) begin @(negedge clk); n++; end
    check_eq("t4_to_latency", n, 81);
    check_eq("t4_err", scan_err_count, 1);
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t4_to_pulses", to_cnt, 3);
    check_eq("t4_cycles", scan_cycles_done, 1);
    check_eq("t4_busy", busy, 0);

    // Bad response, then good response landing on the timeout cycle
    scan_retry_max = 4'd1; scan_period_ms = 16'd100;
    scan_en = 1'b1;
    get_frame(1'b0, -1, fb, span, holds);
    check_eq("t5_frame0", fb, F_RD);
    repeat (10) @(negedge clk);
    rsp_frame_end = 1'b1; rsp_ok = 1'b0;
    @(negedge clk);
    rsp_frame_end = 1'b0;
    get_frame(1'b0, -1, fb, span, holds);
    check_eq("t5_frame1", fb, F_RD);
    repeat (80) @(negedge clk);
    rsp_frame_end = 1'b1; rsp_ok = 1'b1;
    @(negedge clk);
    rsp_frame_end = 1'b0; rsp_ok = 1'b0;
    @(negedge clk);
    check_eq("t5_cycles", scan_cycles_done, 2);
    check_eq("t5_err", scan_err_count, 1);
    check_eq("t5_to_pulses", to_cnt, 3);
    rsp_frame_end = 1'b1; rsp_ok = 1'b1;
    @(negedge clk);
    rsp_frame_end = 1'b0; rsp_ok = 1'b0;
    @(negedge clk);
    check_eq("t5_stray_rsp", scan_cycles_done, 2);
    scan_en = 1'b0;
    repeat (2) @(negedge clk);

    // Unsupported function code
    scan_func = 8'h07; scan_period_ms = 16'd50;
    scan_en = 1'b1;
    vseen = 0;
    repeat (6) begin @(negedge clk); if (tx_b_v) vseen++; end
    check_eq("t6_no_tx", vseen, 0);
    check_eq("t6_err", scan_err_count, 2);
    check_eq("t6_busy", busy, 1);
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t6_idle", busy, 0);

    // scan_en dropped after 3 bytes: frame still completes
    scan_func = 8'h03; scan_period_ms = 16'd0; scan_retry_max = 4'd0;
    scan_en = 1'b1;
    get_frame(1'b0, 3, fb, span, holds);
    check_eq("t6_drop_frame", fb, F_RD);
    repeat (3) @(negedge clk);
    check_eq("t6_drop_idle", busy, 0);
    check_eq("t6_drop_cycles", scan_cycles_done, 2);
    check_eq("t6_drop_err", scan_err_count, 2);

    // Reset mid-frame
    scan_en = 1'b1;
    n = 0;
    while (!tx_b_v && n < 20) begin @(negedge clk); n++; end
    check_eq("rst_mid_started", tx_b_v, 1);
    tx_b_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_v", tx_b_v, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_err", scan_err_count, 0);
    rst = 1'b0; scan_en = 1'b0;
    vseen = 0;
    repeat (4) begin @(negedge clk); if (tx_b_v) vseen++; end
    check_eq("rst_mid_quiet", vseen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
